// File: rtl/gate_bist_pkg.sv
// Shared types and golden gate function for the gate BIST controller.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package gate_bist_pkg;

  typedef enum logic [2:0] {
    AND  = 3'd0,
    OR   = 3'd1,
    XOR  = 3'd2,
    NAND = 3'd3,
    NOR  = 3'd4,
    XNOR = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_e;

  // Expected gate output for the low n bits of vec; unknown ops expect 0.
  function automatic logic gate_ref(op_e op, logic [7:0] vec, int n);
    logic all1;
    logic any1;
    logic par;
    all1 = 1'b1;
    any1 = 1'b0;
    par  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        all1 = all1 & vec[i];
        any1 = any1 | vec[i];
        par  = par ^ vec[i];
      end
    end
    case (op)
      AND:     return all1;
      OR:      return any1;
      XOR:     return par;
      NAND:    return ~all1;
      NOR:     return ~any1;
      XNOR:    return ~par;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Bundle of stimulus, response and result signals between the BIST controller and the board.
// Latency: n/a (wiring only).
// Backpressure: none; start is a level sampled by the controller when idle.
interface gate_bist_ctrl_if
  import gate_bist_pkg::*;
#(
  parameter int N_IN = 2
);
  logic            start;
  logic [2:0]      op_sel;
  logic [N_IN-1:0] dut_in;
  logic            dut_y;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] fail_vec;
  logic            fail_y;

  // Controller side
  modport master (
    input  start, op_sel, dut_y,
    output dut_in, busy, done, pass, err_count, fail_vec, fail_y
  );

  // Board / gate-under-test side
  modport slave (
    output start, op_sel, dut_y,
    input  dut_in, busy, done, pass, err_count, fail_vec, fail_y
  );
endinterface

// File: rtl/gate_bist_ref_model.sv
// Combinational golden model: expected gate output for an op and input vector.
// Latency: 0 cycles.
// Backpressure: none.
module gate_bist_ref_model
  import gate_bist_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op,
  input  logic [N_IN-1:0] vec,
  output logic            y_exp
);

  logic [7:0] vec_ext;

  // Widen the vector to the function's fixed 8-bit argument and evaluate
  always_comb begin
    vec_ext           = '0;
    vec_ext[N_IN-1:0] = vec;
    y_exp             = gate_ref(op_e'(op), vec_ext, N_IN);
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// Sweeps all 2**N_IN input vectors into a gate, holds each HOLD_CYCLES, checks dut_y against the golden model.
// Latency: busy for 2**N_IN*HOLD_CYCLES cycles after start, then a one-cycle done pulse.
// Backpressure: none; start ignored unless idle. Optional first-failure log: GATE_BIST_FAILLOG_EN.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 10
) (
  input logic              clk,
  input logic              rst_n,
  gate_bist_ctrl_if.master bus
);

  localparam int VW = N_IN + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [VW-1:0] VEC_LAST  = VW'((1 << N_IN) - 1);

  state_e          state_q, state_d;
  logic [VW-1:0]   vec_cnt_q, vec_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [2:0]      op_q, op_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [VW-1:0]   err_count_q, err_count_d;
  logic            y_exp;
  logic            cmp_now;
  logic            mismatch;

  gate_bist_ref_model #(.N_IN(N_IN)) u_ref (
    .op    (op_q),
    .vec   (vec_cnt_q[N_IN-1:0]),
    .y_exp (y_exp)
  );

  // The response is judged on the last hold cycle so slow gates have settled
  assign cmp_now  = (state_q == APPLY) && (hold_cnt_q == HOLD_LAST);
  assign mismatch = cmp_now && (bus.dut_y != y_exp);

  // Next-state and next-output computation for the sweep sequencer
  always_comb begin
    state_d     = state_q;
    vec_cnt_d   = vec_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    op_d        = op_q;
    dut_in_d    = dut_in_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = APPLY;
          vec_cnt_d   = '0;
          hold_cnt_d  = '0;
          op_d        = bus.op_sel;
          err_count_d = '0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          dut_in_d    = '0;
        end
      end
      APPLY: begin
        if (cmp_now) begin
          hold_cnt_d = '0;
          if (mismatch) begin
            err_count_d = err_count_q + VW'(1);
          end
          if (vec_cnt_q == VEC_LAST) begin
            state_d  = DONE;
            busy_d   = 1'b0;
            dut_in_d = '0;
            done_d   = 1'b1;
            pass_d   = (err_count_d == '0);
          end else begin
            vec_cnt_d = vec_cnt_q + VW'(1);
            dut_in_d  = vec_cnt_d[N_IN-1:0];
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register sequencer state and all outputs; reset aborts any sweep silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      op_q        <= '0;
      dut_in_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_cnt_q   <= vec_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      op_q        <= op_d;
      dut_in_q    <= dut_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;

`ifdef GATE_BIST_FAILLOG_EN
  logic [N_IN-1:0] fail_vec_q, fail_vec_d;
  logic            fail_y_q, fail_y_d;

  // Keep only the first mismatch of a sweep (error count still zero); start clears the log
  always_comb begin
    fail_vec_d = fail_vec_q;
    fail_y_d   = fail_y_q;
    if ((state_q == IDLE) && bus.start) begin
      fail_vec_d = '0;
      fail_y_d   = 1'b0;
    end else if (mismatch && (err_count_q == '0)) begin
      fail_vec_d = vec_cnt_q[N_IN-1:0];
      fail_y_d   = bus.dut_y;
    end
  end

  // First-failure capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vec_q <= '0;
      fail_y_q   <= 1'b0;
    end else begin
      fail_vec_q <= fail_vec_d;
      fail_y_q   <= fail_y_d;
    end
  end

  assign bus.fail_vec = fail_vec_q;
  assign bus.fail_y   = fail_y_q;
`else
  assign bus.fail_vec = '0;
  assign bus.fail_y   = 1'b0;
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: three instances (2-in/hold 10, 3-in/hold 10, 2-in/hold 1) driven by a
// truth-table gate, checked every cycle against a sweep-time model, plus hand-computed result pins.
// Ends with one summary line.
module tb_gate_bist_ctrl;

  localparam int N0 = 2, H0 = 10;
  localparam int N1 = 3, H1 = 10;
  localparam int N2 = 2, H2 = 1;
`ifdef GATE_BIST_FAILLOG_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  gate_bist_ctrl_if #(.N_IN(N0)) if0 ();
  gate_bist_ctrl_if #(.N_IN(N1)) if1 ();
  gate_bist_ctrl_if #(.N_IN(N2)) if2 ();

  gate_bist_ctrl #(.N_IN(N0), .HOLD_CYCLES(H0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  gate_bist_ctrl #(.N_IN(N1), .HOLD_CYCLES(H1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
  gate_bist_ctrl #(.N_IN(N2), .HOLD_CYCLES(H2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));

  // Stimulus: start/op per instance and the gate under test as a truth table
  logic       start_r [3];
  logic [2:0] op_r    [3];
  logic [7:0] tt      [3];

  assign if0.start  = start_r[0];
  assign if1.start  = start_r[1];
  assign if2.start  = start_r[2];
  assign if0.op_sel = op_r[0];
  assign if1.op_sel = op_r[1];
  assign if2.op_sel = op_r[2];
  assign if0.dut_y  = tt[0][if0.dut_in];
  assign if1.dut_y  = tt[1][if1.dut_in];
  assign if2.dut_y  = tt[2][if2.dut_in];

  logic       act_busy [3], act_done [3], act_pass [3], act_fy [3];
  logic [7:0] act_din  [3], act_fv [3];
  logic [8:0] act_err  [3];

  assign act_busy[0] = if0.busy;  assign act_busy[1] = if1.busy;  assign act_busy[2] = if2.busy;
  assign act_done[0] = if0.done;  assign act_done[1] = if1.done;  assign act_done[2] = if2.done;
  assign act_pass[0] = if0.pass;  assign act_pass[1] = if1.pass;  assign act_pass[2] = if2.pass;
  assign act_fy[0]   = if0.fail_y; assign act_fy[1] = if1.fail_y; assign act_fy[2] = if2.fail_y;
  assign act_din[0]  = 8'(if0.dut_in);   assign act_din[1] = 8'(if1.dut_in);   assign act_din[2] = 8'(if2.dut_in);
  assign act_fv[0]   = 8'(if0.fail_vec); assign act_fv[1]  = 8'(if1.fail_vec); assign act_fv[2]  = 8'(if2.fail_vec);
  assign act_err[0]  = 9'(if0.err_count); assign act_err[1] = 9'(if1.err_count); assign act_err[2] = 9'(if2.err_count);

  function automatic int nv(input int i);
    case (i)
      0:       return N0;
      1:       return N1;
      default: return N2;
    endcase
  endfunction

  function automatic int hv(input int i);
    case (i)
      0:       return H0;
      1:       return H1;
      default: return H2;
    endcase
  endfunction

  function automatic int sweep_len(input int i);
    return (1 << nv(i)) * hv(i);
  endfunction

  // Gate truth from the number of ones among the n inputs
  function automatic int refb(input int op, input int v, input int n);
    int pc;
    pc = $countones(v);
    case (op)
      0:       return (pc == n) ? 1 : 0;
      1:       return (pc > 0) ? 1 : 0;
      2:       return pc % 2;
      3:       return (pc == n) ? 0 : 1;
      4:       return (pc == 0) ? 1 : 0;
      5:       return 1 - (pc % 2);
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] table_of(input int op, input int n);
    logic [7:0] r;
    r = '0;
    for (int v = 0; v < (1 << n); v++) r[v] = refb(op, v, n) != 0;
    return r;
  endfunction

  function automatic int nmis(input int op, input logic [7:0] t, input int n, input int upto);
    int c;
    c = 0;
    for (int v = 0; v < upto; v++) if (int'(t[v]) != refb(op, v, n)) c++;
    return c;
  endfunction

  function automatic int first_fail(input int op, input logic [7:0] t, input int n, input int upto);
    for (int v = 0; v < upto; v++) if (int'(t[v]) != refb(op, v, n)) return v;
    return -1;
  endfunction

  // Model: ph = cycles since the accepted start edge, -1 when idle
  int         ph    [3] = '{-1, -1, -1};
  int         m_op  [3] = '{0, 0, 0};
  logic [7:0] m_tt  [3] = '{8'h0, 8'h0, 8'h0};
  int         l_err [3] = '{0, 0, 0};
  int         l_pass[3] = '{0, 0, 0};
  int         l_fv  [3] = '{0, 0, 0};
  int         l_fy  [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      int f;
      if (!rst_n) begin
        ph[i] = -1; l_err[i] = 0; l_pass[i] = 0; l_fv[i] = 0; l_fy[i] = 0;
      end else if (ph[i] < 0) begin
        if (start_r[i] === 1'b1) begin
          ph[i] = 0; m_op[i] = int'(op_r[i]); m_tt[i] = tt[i];
          l_err[i] = 0; l_pass[i] = 0; l_fv[i] = 0; l_fy[i] = 0;
        end
      end else if (ph[i] >= sweep_len(i)) begin
        f        = first_fail(m_op[i], m_tt[i], nv(i), 1 << nv(i));
        l_err[i] = nmis(m_op[i], m_tt[i], nv(i), 1 << nv(i));
        l_pass[i] = (l_err[i] == 0) ? 1 : 0;
        l_fv[i]  = (f < 0) ? 0 : f;
        l_fy[i]  = (f < 0) ? 0 : int'(m_tt[i][f]);
        ph[i]    = -1;
      end else begin
        ph[i]++;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int busy_tot[3] = '{0, 0, 0};
  int done_tot[3] = '{0, 0, 0};
  int bbase[3]    = '{0, 0, 0};
  int dbase[3]    = '{0, 0, 0};

  // Hand-computed expectations handed to the compare process
  int pin_seq = 0, pin_ack = 0;
  int pin_i, pin_err, pin_pass, pin_busy, pin_done, pin_fv, pin_fy;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  // Single compare process: model vs DUT every cycle, plus pending pins
  always @(negedge clk) begin
    int n, len, k, fidx, eb, ed, edi, ee, ep, efv, efy;
    if (pin_seq != pin_ack) begin
      pin_ack = pin_seq;
      chk("pin.err_count", 32'(act_err[pin_i]), 32'(pin_err));
      chk("pin.pass", 32'(act_pass[pin_i]), 32'(pin_pass));
      chk("pin.busy_low", 32'(act_busy[pin_i]), 32'd0);
      chk("pin.dut_in_zero", 32'(act_din[pin_i]), 32'd0);
      chk("pin.done_pulses", 32'(done_tot[pin_i] - dbase[pin_i]), 32'(pin_done));
      chk("pin.fail_vec", 32'(act_fv[pin_i]), 32'(pin_fv));
      chk("pin.fail_y", 32'(act_fy[pin_i]), 32'(pin_fy));
      if (pin_busy >= 0) chk("pin.busy_cycles", 32'(busy_tot[pin_i] - bbase[pin_i]), 32'(pin_busy));
    end
    for (int i = 0; i < 3; i++) begin
      n   = nv(i);
      len = sweep_len(i);
      if (ph[i] < 0) begin
        eb = 0; ed = 0; edi = 0; ee = l_err[i]; ep = l_pass[i]; efv = l_fv[i]; efy = l_fy[i];
      end else begin
        k    = (ph[i] < len) ? ph[i] / hv(i) : (1 << n);
        eb   = (ph[i] < len) ? 1 : 0;
        ed   = (ph[i] == len) ? 1 : 0;
        edi  = (ph[i] < len) ? k : 0;
        ee   = nmis(m_op[i], m_tt[i], n, k);
        ep   = (ed == 1 && ee == 0) ? 1 : 0;
        fidx = first_fail(m_op[i], m_tt[i], n, k);
        efv  = (fidx < 0) ? 0 : fidx;
        efy  = (fidx < 0) ? 0 : int'(m_tt[i][fidx]);
      end
      if (!FL) begin
        efv = 0;
        efy = 0;
      end
      chk($sformatf("u%0d.busy", i), 32'(act_busy[i]), 32'(eb));
      chk($sformatf("u%0d.done", i), 32'(act_done[i]), 32'(ed));
      chk($sformatf("u%0d.dut_in", i), 32'(act_din[i]), 32'(edi));
      chk($sformatf("u%0d.err_count", i), 32'(act_err[i]), 32'(ee));
      chk($sformatf("u%0d.pass", i), 32'(act_pass[i]), 32'(ep));
      chk($sformatf("u%0d.fail_vec", i), 32'(act_fv[i]), 32'(efv));
      chk($sformatf("u%0d.fail_y", i), 32'(act_fy[i]), 32'(efy));
      if (act_busy[i] === 1'b1) busy_tot[i]++;
      if (act_done[i] === 1'b1) done_tot[i]++;
    end
  end

  task automatic pin(input int i, input int e, input int p, input int b, input int d,
                     input int fv, input int fy);
    pin_i = i; pin_err = e; pin_pass = p; pin_busy = b; pin_done = d; pin_fv = fv; pin_fy = fy;
    pin_seq++;
    @(negedge clk); #1;
  endtask

  // One sweep on instance i; optional extra start pulse (with a new op) at cycle rep after start
  task automatic sweep(input int i, input int op, input logic [7:0] t, input int rep);
    int len;
    len = sweep_len(i);
    @(negedge clk); #1;
    bbase[i] = busy_tot[i];
    dbase[i] = done_tot[i];
    tt[i] = t;
    op_r[i] = 3'(op);
    start_r[i] = 1'b1;
    for (int c = 1; c <= len + 3; c++) begin
      @(negedge clk); #1;
      start_r[i] = (c == rep);
      if (c == rep) op_r[i] = 3'($urandom_range(0, 7));
    end
    start_r[i] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0;
      op_r[i] = 3'd0;
      tt[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    pin(0, 0, 0, 0, 0, 0, 0);
    pin(1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Correct AND gate
    sweep(0, 0, table_of(0, 2), -1);
    pin(0, 0, 1, 40, 1, 0, 0);
    // OR gate checked as AND: vectors 1 and 2 fail
    sweep(0, 0, table_of(1, 2), -1);
    pin(0, 2, 0, 40, 1, FL ? 1 : 0, FL ? 1 : 0);
    // Stuck-at-1 output checked as 3-input NAND: only vector 7 fails
    sweep(1, 3, 8'hFF, -1);
    pin(1, 1, 0, 80, 1, FL ? 7 : 0, FL ? 1 : 0);
    // Re-pulsed start mid-sweep with a new op, then in the DONE cycle: both ignored
    sweep(0, 0, table_of(0, 2), 15);
    pin(0, 0, 1, 40, 1, 0, 0);
    sweep(0, 0, table_of(0, 2), 41);
    pin(0, 0, 1, 40, 1, 0, 0);

    // Reset mid-sweep, asserted just after a rising edge
    @(negedge clk); #1;
    bbase[0] = busy_tot[0];
    dbase[0] = done_tot[0];
    tt[0] = table_of(1, 2);
    op_r[0] = 3'd0;
    start_r[0] = 1'b1;
    @(negedge clk); #1;
    start_r[0] = 1'b0;
    repeat (22) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    pin(0, 0, 0, -1, 0, 0, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    sweep(0, 0, table_of(1, 2), -1);
    pin(0, 2, 0, 40, 1, FL ? 1 : 0, FL ? 1 : 0);

    // Hold of one cycle: correct XOR, then invalid op 6 expecting all zeros
    sweep(2, 2, table_of(2, 2), -1);
    pin(2, 0, 1, 4, 1, 0, 0);
    sweep(2, 6, table_of(2, 2), -1);
    pin(2, 2, 0, 4, 1, FL ? 1 : 0, FL ? 1 : 0);

    // Randomised sweeps: random instance, op (incl. invalid), gate table and extra start pulses
    for (int r = 0; r < 30; r++) begin
      int i, op, len, rep;
      logic [7:0] t;
      i   = $urandom_range(0, 2);
      op  = $urandom_range(0, 7);
      len = sweep_len(i);
      if ($urandom_range(0, 1) == 1)
        t = table_of(op % 6, nv(i)) ^ 8'(1 << $urandom_range(0, 7));
      else
        t = 8'($urandom);
      rep = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len + 1) : -1;
      sweep(i, op, t, rep);
    end

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
